// File: rtl/leglite_pkg.sv
// leglite_pkg: shared fetch-stage types and constants
package leglite_pkg;
  localparam int ILEN = 16;
  localparam logic [ILEN-1:0] INSTR_NOP = '0;
  typedef enum logic [1:0] {IDLE, REQ_LO, REQ_HI, HOLD} fetch_state_t;
endpackage

// File: rtl/fetch_wdog.sv
// fetch_wdog: per-byte ack wait counter, expires after LIMIT waiting cycles
module fetch_wdog #(
  parameter int LIMIT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign expired_o = en_i && (cnt_q >= W'(LIMIT - 1));
  always_comb cnt_d = clr_i ? '0 : (en_i && !expired_o) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: two-byte little-endian instruction fetch from an 8-bit program memory
module instr_fetch import leglite_pkg::*; #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic [15:0]     pc_i,
  input  logic            flush_i,
  output logic            mem_req_o,
  output logic [15:0]     mem_addr_o,
  input  logic            mem_ack_i,
  input  logic [7:0]      mem_rdata_i,
  output logic [ILEN-1:0] instr_o,
  output logic            instr_valid_o,
  input  logic            decode_ready_i,
  output logic            fetch_busy_o,
  output logic            bus_err_o,
  output logic            misalign_o
);
  fetch_state_t state_q, state_d;
  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic [7:0] lo_q, lo_d;
  logic bus_err_q, bus_err_d, misalign_q, misalign_d;
  logic in_req, accept, restart, expired;
  assign in_req = state_q == REQ_LO || state_q == REQ_HI;
  assign accept = state_q == HOLD && decode_ready_i;
  // flush and consume both restart at the current pc; flush overrides a same-cycle ack
  assign restart = state_q == IDLE || flush_i || accept;
  always_comb begin
    state_d = state_q;
    fetch_pc_d = fetch_pc_q;
    instr_d = instr_q;
    lo_d = lo_q;
    bus_err_d = 1'b0;
    misalign_d = 1'b0;
    if (restart) begin
      state_d = REQ_LO;
      fetch_pc_d = {pc_i[15:1], 1'b0};
      misalign_d = pc_i[0];
    end else if (in_req && mem_ack_i) begin
      if (state_q == REQ_LO) begin
        lo_d = mem_rdata_i;
        state_d = REQ_HI;
      end else begin
        instr_d = {mem_rdata_i, lo_q};
        state_d = HOLD;
      end
    end else if (expired) begin
      instr_d = INSTR_NOP;
      bus_err_d = 1'b1;
      state_d = HOLD;
    end
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      fetch_pc_q <= '0;
      instr_q <= '0;
      lo_q <= '0;
      bus_err_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q <= instr_d;
      lo_q <= lo_d;
      bus_err_q <= bus_err_d;
      misalign_q <= misalign_d;
    end
  end
  fetch_wdog #(.LIMIT(ACK_TIMEOUT)) u_wdog (
    .clk_i     (clock_i),
    .rst_i     (reset_i),
    .clr_i     (state_d != state_q || flush_i || mem_ack_i),
    .en_i      (in_req),
    .expired_o (expired)
  );
  assign mem_req_o = in_req;
  assign mem_addr_o = state_q == REQ_HI ? fetch_pc_q + 16'd1 : state_q == REQ_LO ? fetch_pc_q : '0;
  assign instr_o = instr_q;
  assign instr_valid_o = state_q == HOLD;
  assign fetch_busy_o = !accept;
  assign bus_err_o = bus_err_q;
  assign misalign_o = misalign_q;
endmodule
